// File: rtl/sprite_motion_ctrl_pkg.sv
// sprite_pkg: shared definitions for the sprite motion controller.
//   - state_t   : controller FSM states (IDLE, CALC_X, CALC_Y, PUBLISH)
//   - DIR_POS / DIR_NEG : per-axis direction encoding (0 = +, 1 = -)
//   - DEF_*     : default geometry and speed constants
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC_X  = 2'd1,
    CALC_Y  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int DEF_BOX_W   = 50;
  localparam int DEF_BOX_H   = 50;
  localparam int DEF_DRAW_W  = 640;
  localparam int DEF_DRAW_H  = 480;
  localparam int DEF_INIT_XS = 1;
  localparam int DEF_INIT_YS = 1;
  localparam int DEF_SPD_W   = 4;

  localparam int POS_W = 16;

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// axis_step: combinational next-position for one axis of the bouncing box.
// Optional build macro: SPRITE_MOTION_WRAP_EN (edges wrap instead of reflect).
// Ports:
//   pos   in  16     current origin on this axis
//   spd   in  SPD_W  pixels per frame (0 = no motion, no hit)
//   dir   in  1      current direction (DIR_POS / DIR_NEG)
//   limit in  16     largest legal origin (drawable size - box size)
//   npos  out 16     next origin
//   ndir  out 1      next direction
//   hit   out 1      edge reached this step (reflect or wrap)
module axis_step
  import sprite_pkg::*;
#(
  parameter int SPD_W = DEF_SPD_W
) (
  input  logic [POS_W-1:0] pos,
  input  logic [SPD_W-1:0] spd,
  input  logic             dir,
  input  logic [POS_W-1:0] limit,
  output logic [POS_W-1:0] npos,
  output logic             ndir,
  output logic             hit
);

  // Comparisons are done one bit wider so pos + spd can never wrap.
  logic [POS_W-1:0] spd16;
  logic [POS_W:0]   pos_e;
  logic [POS_W:0]   spd_e;
  logic [POS_W:0]   lim_e;
  logic [POS_W:0]   sum_e;
  logic [POS_W-1:0] diff16;

  assign spd16  = {{(POS_W-SPD_W){1'b0}}, spd};
  assign pos_e  = {1'b0, pos};
  assign spd_e  = {1'b0, spd16};
  assign lim_e  = {1'b0, limit};
  assign sum_e  = pos_e + spd_e;
  assign diff16 = pos - spd16;

`ifdef SPRITE_MOTION_WRAP_EN
  // Both results are small non-negative values once the wrap condition
  // holds, so 16-bit modular arithmetic gives the exact answer.
  logic [POS_W-1:0] wrap_hi;
  logic [POS_W-1:0] wrap_lo;
  assign wrap_hi = pos + spd16 - limit - 16'd1;
  assign wrap_lo = limit + 16'd1 - (spd16 - pos);
`endif

  always_comb begin
    npos = pos;
    ndir = dir;
    hit  = 1'b0;
    if (spd != '0) begin
`ifdef SPRITE_MOTION_WRAP_EN
      if (dir == DIR_POS) begin
        if (sum_e > lim_e) begin
          npos = wrap_hi;
          hit  = 1'b1;
        end else begin
          npos = sum_e[POS_W-1:0];
        end
      end else begin
        if (pos_e < spd_e) begin
          npos = wrap_lo;
          hit  = 1'b1;
        end else begin
          npos = diff16;
        end
      end
`else
      if (dir == DIR_POS) begin
        if (sum_e >= lim_e) begin
          npos = limit;
          ndir = DIR_NEG;
          hit  = 1'b1;
        end else begin
          npos = sum_e[POS_W-1:0];
        end
      end else begin
        // Landing exactly on 0 also counts as touching the edge.
        if (pos_e <= spd_e) begin
          npos = '0;
          ndir = DIR_POS;
          hit  = 1'b1;
        end else begin
          npos = diff16;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous motion controller for the bouncing
// picture box. The origin advances once per frame on the rising edge of the
// synchronised vsync and is published atomically 4 cycles after that tick.
// Optional build macro: SPRITE_MOTION_WRAP_EN (handled inside axis_step).
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous active-high reset
//   vsync      in   raw vertical sync, active-high
//   cfg_valid  in   speed/pause request
//   cfg_ready  out  high only while idle; accept = cfg_valid & cfg_ready
//   cfg_xs     in   requested x speed
//   cfg_ys     in   requested y speed
//   cfg_pause  in   1 = freeze motion
//   box_x      out  published origin x
//   box_y      out  published origin y
//   pos_upd    out  one-cycle pulse when the published origin changes
//   hit_x      out  one-cycle pulse, x edge reached this frame
//   hit_y      out  one-cycle pulse, y edge reached this frame
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int BOX_W   = DEF_BOX_W,
  parameter int BOX_H   = DEF_BOX_H,
  parameter int DRAW_W  = DEF_DRAW_W,
  parameter int DRAW_H  = DEF_DRAW_H,
  parameter int INIT_XS = DEF_INIT_XS,
  parameter int INIT_YS = DEF_INIT_YS,
  parameter int SPD_W   = DEF_SPD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SPD_W-1:0] cfg_xs,
  input  logic [SPD_W-1:0] cfg_ys,
  input  logic             cfg_pause,
  output logic [15:0]      box_x,
  output logic [15:0]      box_y,
  output logic             pos_upd,
  output logic             hit_x,
  output logic             hit_y
);

  localparam logic [POS_W-1:0] LIM_X = POS_W'(DRAW_W - BOX_W);
  localparam logic [POS_W-1:0] LIM_Y = POS_W'(DRAW_H - BOX_H);

  state_t state_reg, state_next;

  logic vs_meta_reg, vs_sync_reg, vs_prev_reg;
  logic tick;
  logic frame_start;
  logic cfg_accept;

  logic [SPD_W-1:0] xs_reg, ys_reg;
  logic             pause_reg;
  logic [SPD_W-1:0] sh_xs_reg, sh_ys_reg;
  logic             sh_pause_reg;
  logic             pend_reg;

  logic             dir_x_reg, dir_y_reg;
  logic [POS_W-1:0] nx_reg, ny_reg;
  logic             hx_reg, hy_reg;

  logic [POS_W-1:0] box_x_reg, box_y_reg;
  logic             pos_upd_reg, hit_x_reg, hit_y_reg;

  // Per-axis step units: index 0 = x, index 1 = y.
  logic [POS_W-1:0] ax_pos  [2];
  logic [SPD_W-1:0] ax_spd  [2];
  logic             ax_dir  [2];
  logic [POS_W-1:0] ax_lim  [2];
  logic [POS_W-1:0] ax_npos [2];
  logic             ax_ndir [2];
  logic             ax_hit  [2];

  assign ax_pos[0] = box_x_reg;
  assign ax_spd[0] = xs_reg;
  assign ax_dir[0] = dir_x_reg;
  assign ax_lim[0] = LIM_X;
  assign ax_pos[1] = box_y_reg;
  assign ax_spd[1] = ys_reg;
  assign ax_dir[1] = dir_y_reg;
  assign ax_lim[1] = LIM_Y;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      axis_step #(
        .SPD_W (SPD_W)
      ) u_step (
        .pos   (ax_pos[gi]),
        .spd   (ax_spd[gi]),
        .dir   (ax_dir[gi]),
        .limit (ax_lim[gi]),
        .npos  (ax_npos[gi]),
        .ndir  (ax_ndir[gi]),
        .hit   (ax_hit[gi])
      );
    end
  endgenerate

  // Frame tick: rising edge of the second synchroniser stage.
  assign tick       = vs_sync_reg & ~vs_prev_reg;
  assign cfg_accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cfg_ready   = 1'b0;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        cfg_ready = 1'b1;
        if (tick) begin
          frame_start = 1'b1;
          state_next  = CALC_X;
        end
      end
      CALC_X:  state_next = CALC_Y;
      CALC_Y:  state_next = PUBLISH;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_reg  <= 1'b0;
      vs_sync_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      xs_reg       <= SPD_W'(INIT_XS);
      ys_reg       <= SPD_W'(INIT_YS);
      pause_reg    <= 1'b0;
      sh_xs_reg    <= '0;
      sh_ys_reg    <= '0;
      sh_pause_reg <= 1'b0;
      pend_reg     <= 1'b0;
      dir_x_reg    <= DIR_POS;
      dir_y_reg    <= DIR_POS;
      nx_reg       <= '0;
      ny_reg       <= '0;
      hx_reg       <= 1'b0;
      hy_reg       <= 1'b0;
      box_x_reg    <= '0;
      box_y_reg    <= '0;
      pos_upd_reg  <= 1'b0;
      hit_x_reg    <= 1'b0;
      hit_y_reg    <= 1'b0;
    end else begin
      vs_meta_reg <= vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;

      pos_upd_reg <= 1'b0;
      hit_x_reg   <= 1'b0;
      hit_y_reg   <= 1'b0;

      // A request accepted in the very cycle of the tick is applied to that
      // frame directly rather than waiting a whole frame in the shadow.
      if (cfg_accept && !frame_start) begin
        sh_xs_reg    <= cfg_xs;
        sh_ys_reg    <= cfg_ys;
        sh_pause_reg <= cfg_pause;
        pend_reg     <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            if (cfg_accept) begin
              xs_reg    <= cfg_xs;
              ys_reg    <= cfg_ys;
              pause_reg <= cfg_pause;
            end else if (pend_reg) begin
              xs_reg    <= sh_xs_reg;
              ys_reg    <= sh_ys_reg;
              pause_reg <= sh_pause_reg;
            end
            pend_reg <= 1'b0;
          end
        end
        CALC_X: begin
          if (pause_reg) begin
            nx_reg <= box_x_reg;
            hx_reg <= 1'b0;
          end else begin
            nx_reg    <= ax_npos[0];
            dir_x_reg <= ax_ndir[0];
            hx_reg    <= ax_hit[0];
          end
        end
        CALC_Y: begin
          if (pause_reg) begin
            ny_reg <= box_y_reg;
            hy_reg <= 1'b0;
          end else begin
            ny_reg    <= ax_npos[1];
            dir_y_reg <= ax_ndir[1];
            hy_reg    <= ax_hit[1];
          end
        end
        PUBLISH: begin
          box_x_reg   <= nx_reg;
          box_y_reg   <= ny_reg;
          pos_upd_reg <= (nx_reg != box_x_reg) || (ny_reg != box_y_reg);
          hit_x_reg   <= hx_reg;
          hit_y_reg   <= hy_reg;
        end
        default: ;
      endcase
    end
  end

  assign box_x   = box_x_reg;
  assign box_y   = box_y_reg;
  assign pos_upd = pos_upd_reg;
  assign hit_x   = hit_x_reg;
  assign hit_y   = hit_y_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Testbench for sprite_motion_ctrl: directed frame sequences plus randomized
// speed/pause reconfiguration, checked against a behavioural model of the
// box motion rules. Honours SPRITE_MOTION_WRAP_EN in the model.
module tb_sprite_motion_ctrl;

  localparam int LX = 640 - 50;
  localparam int LY = 480 - 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_xs = '0;
  logic [3:0]  cfg_ys = '0;
  logic        cfg_pause = 1'b0;
  logic [15:0] box_x, box_y;
  logic        pos_upd, hit_x, hit_y;

  sprite_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_xs    (cfg_xs),
    .cfg_ys    (cfg_ys),
    .cfg_pause (cfg_pause),
    .box_x     (box_x),
    .box_y     (box_y),
    .pos_upd   (pos_upd),
    .hit_x     (hit_x),
    .hit_y     (hit_y)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_upd = 0;
  int n_hx  = 0;
  int n_hy  = 0;
  int n_frame = 0;

  // Pulse counters: number of cycles each pulse output was seen high.
  always @(negedge clk) begin
    if (pos_upd === 1'b1) n_upd++;
    if (hit_x === 1'b1) n_hx++;
    if (hit_y === 1'b1) n_hy++;
  end

  // Behavioural model state; direction is +1 / -1.
  int m_x, m_y, m_dx, m_dy, m_xs, m_ys;
  bit m_pause, m_pend, m_spause;
  int m_sxs, m_sys;
  int e_upd, e_hx, e_hy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    m_xs = 1; m_ys = 1; m_pause = 0; m_pend = 0;
  endtask

  task automatic step(input int pos, input int spd, input int dir, input int lim,
                      output int np, output int nd, output int h);
    np = pos; nd = dir; h = 0;
    if (spd != 0) begin
`ifdef SPRITE_MOTION_WRAP_EN
      if (dir > 0) begin
        if (pos + spd > lim) begin np = pos + spd - lim - 1; h = 1; end
        else np = pos + spd;
      end else begin
        if (pos < spd) begin np = lim + 1 - (spd - pos); h = 1; end
        else np = pos - spd;
      end
`else
      if (dir > 0) begin
        if (pos + spd >= lim) begin np = lim; nd = -1; h = 1; end
        else np = pos + spd;
      end else begin
        if (pos <= spd) begin np = 0; nd = 1; h = 1; end
        else np = pos - spd;
      end
`endif
    end
  endtask

  task automatic model_frame();
    int nx, ny, ndx, ndy, hx, hy;
    if (m_pend) begin
      m_xs = m_sxs; m_ys = m_sys; m_pause = m_spause; m_pend = 0;
    end
    e_upd = 0; e_hx = 0; e_hy = 0;
    if (!m_pause) begin
      step(m_x, m_xs, m_dx, LX, nx, ndx, hx);
      step(m_y, m_ys, m_dy, LY, ny, ndy, hy);
      e_upd = ((nx != m_x) || (ny != m_y)) ? 1 : 0;
      e_hx = hx; e_hy = hy;
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  // Idle-time request: must be accepted in the same cycle.
  task automatic cfg_send(input int xs, input int ys, input bit p);
    cfg_xs = 4'(xs); cfg_ys = 4'(ys); cfg_pause = p;
    cfg_valid = 1'b1;
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    m_sxs = xs; m_sys = ys; m_spause = p; m_pend = 1;
  endtask

  // One vsync frame; optionally issue a request while the FSM is busy and
  // hold it until it is accepted.
  task automatic run_frame(input bit busy_cfg, input int xs, input int ys, input bit p);
    int u0, hx0, hy0;
    u0 = n_upd; hx0 = n_hx; hy0 = n_hy;
    model_frame();
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    if (busy_cfg) begin
      cfg_xs = 4'(xs); cfg_ys = 4'(ys); cfg_pause = p;
      cfg_valid = 1'b1;
      chk("cfg_ready_busy", {31'd0, cfg_ready}, 32'd0);
      for (int k = 0; k < 20 && cfg_ready !== 1'b1; k++) @(negedge clk);
      chk("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      m_sxs = xs; m_sys = ys; m_spause = p; m_pend = 1;
    end
    repeat (9) @(negedge clk);
    n_frame++;
    chk("box_x", {16'd0, box_x}, 32'(m_x));
    chk("box_y", {16'd0, box_y}, 32'(m_y));
    chk("pos_upd_cnt", 32'(n_upd - u0), 32'(e_upd));
    chk("hit_x_cnt", 32'(n_hx - hx0), 32'(e_hx));
    chk("hit_y_cnt", 32'(n_hy - hy0), 32'(e_hy));
    $display("frame %0d: box=(%0d,%0d) model=(%0d,%0d) upd=%0d hx=%0d hy=%0d",
             n_frame, box_x, box_y, m_x, m_y, e_upd, e_hx, e_hy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_box_x"}, {16'd0, box_x}, 32'd0);
    chk({tag, "_box_y"}, {16'd0, box_y}, 32'd0);
    chk({tag, "_pos_upd"}, {31'd0, pos_upd}, 32'd0);
    chk({tag, "_hit_x"}, {31'd0, hit_x}, 32'd0);
    chk({tag, "_hit_y"}, {31'd0, hit_y}, 32'd0);
    chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
  endtask

  initial begin
    int u0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Defaults: three frames -> (3,3), three update pulses.
    u0 = n_upd;
    repeat (3) run_frame(0, 0, 0, 0);
    chk("default_x3", {16'd0, box_x}, 32'd3);
    chk("default_y3", {16'd0, box_y}, 32'd3);
    chk("default_upd3", 32'(n_upd - u0), 32'd3);

    // Drive x to 588 heading +, then step with xs=4 across the right edge.
    cfg_send(15, 0, 0);
    repeat (39) run_frame(0, 0, 0, 0);
    chk("x_at_588", {16'd0, box_x}, 32'd588);
    cfg_send(4, 0, 0);
    run_frame(0, 0, 0, 0);
`ifndef SPRITE_MOTION_WRAP_EN
    chk("x_edge_590", {16'd0, box_x}, 32'd590);
`endif
    run_frame(0, 0, 0, 0);
`ifndef SPRITE_MOTION_WRAP_EN
    chk("x_back_586", {16'd0, box_x}, 32'd586);
`endif

    // Drive y to the bottom, back up to 2 heading -, then ys=5 across top.
    cfg_send(0, 15, 0);
    repeat (57) run_frame(0, 0, 0, 0);
    cfg_send(0, 8, 0);
    run_frame(0, 0, 0, 0);
`ifndef SPRITE_MOTION_WRAP_EN
    chk("y_at_2", {16'd0, box_y}, 32'd2);
`endif
    cfg_send(0, 5, 0);
    run_frame(0, 0, 0, 0);
`ifndef SPRITE_MOTION_WRAP_EN
    chk("y_edge_0", {16'd0, box_y}, 32'd0);
`endif
    run_frame(0, 0, 0, 0);
`ifndef SPRITE_MOTION_WRAP_EN
    chk("y_back_5", {16'd0, box_y}, 32'd5);
`endif

    // xs=7, ys=0: x moves by 7, y frozen, no y hit.
    cfg_send(7, 0, 0);
    run_frame(0, 0, 0, 0);

    // Last request before the tick wins.
    cfg_send(2, 1, 0);
    cfg_send(5, 1, 0);
    run_frame(0, 0, 0, 0);

    // Pause requested while busy (held until ready), five frozen frames,
    // then resume from the same origin.
    run_frame(1, 3, 3, 1);
    u0 = n_upd;
    repeat (5) run_frame(0, 0, 0, 0);
    chk("pause_no_upd", 32'(n_upd - u0), 32'd0);
    cfg_send(3, 3, 0);
    run_frame(0, 0, 0, 0);

    // Randomized reconfiguration.
    for (int i = 0; i < 40; i++) begin
      int sel, rxs, rys;
      bit rp;
      sel = $urandom_range(0, 3);
      rxs = $urandom_range(0, 15);
      rys = $urandom_range(0, 15);
      rp  = ($urandom_range(0, 5) == 0);
      if (sel == 1) cfg_send(rxs, rys, rp);
      run_frame(sel == 2, rxs, rys, rp);
    end

    // Reset asserted during CALC_Y clears outputs without a clock edge.
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_calc_y");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A pending request is discarded by reset.
    cfg_send(9, 9, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    run_frame(0, 0, 0, 0);
    chk("discard_x", {16'd0, box_x}, 32'd1);
    chk("discard_y", {16'd0, box_y}, 32'd1);

    // Approach the right edge to x=589 heading +, then step xs=3.
    cfg_send(15, 0, 0);
    repeat (39) run_frame(0, 0, 0, 0);
    cfg_send(3, 0, 0);
    run_frame(0, 0, 0, 0);
    chk("x_at_589", {16'd0, box_x}, 32'd589);
    run_frame(0, 0, 0, 0);
`ifdef SPRITE_MOTION_WRAP_EN
    chk("wrap_x_1", {16'd0, box_x}, 32'd1);
`else
    chk("reflect_x_590", {16'd0, box_x}, 32'd590);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Frame-synchronous motion controller for the bouncing picture box in the VGA path. It owns the box origin (box_x, box_y) and advances it exactly once per frame on a vsync edge, with reflection at the drawable edges. It publishes the new origin atomically during blanking so the pixel-stage renderer never tears mid-frame. Speed and pause are reconfigured through a valid/ready port that takes effect only at frame boundaries.

Parameters:
BOX_W, 50, box width in pixels
BOX_H, 50, box height in pixels
DRAW_W, 640, drawable width in pixels
DRAW_H, 480, drawable height in pixels
INIT_XS, 1, reset x speed (pixels/frame)
INIT_YS, 1, reset y speed (pixels/frame)
SPD_W, 4, speed field width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  raw vertical sync from timing gen, active-high
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted this cycle when cfg_valid & cfg_ready
cfg_xs  in  SPD_W  new x speed
cfg_ys  in  SPD_W  new y speed
cfg_pause  in  1  1 = freeze motion
box_x  out  16  published box origin x
box_y  out  16  published box origin y
pos_upd  out  1  one-cycle pulse when box_x/box_y change
hit_x  out  1  one-cycle pulse, x direction reversed this frame
hit_y  out  1  one-cycle pulse, y direction reversed this frame

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Every register clears on rst assertion, with no clock required.
- Reset values: box_x=0, box_y=0, pos_upd=0, hit_x=0, hit_y=0, cfg_ready=1, dir_x=+, dir_y=+, xs=INIT_XS, ys=INIT_YS, pause=0, state=IDLE.
- vsync is registered twice. The frame tick is the rising edge of the second-stage register. Tick-to-publish latency is fixed at 4 cycles.
- FSM:
  - IDLE: waits for tick, then goes to CALC_X.
  - CALC_X: computes nx and dir_x, then goes to CALC_Y.
  - CALC_Y: computes ny and dir_y, then goes to PUBLISH.
  - PUBLISH: box_x<=nx and box_y<=ny. pos_upd=1 if either value changed. hit_x/hit_y pulse here. Returns to IDLE.
- Arithmetic is done at 17 bits to avoid wrap.
  - Moving +: if x+xs >= DRAW_W-BOX_W, then nx=DRAW_W-BOX_W and dir_x flips to -, hit_x=1. Otherwise nx=x+xs.
  - Moving -: if x <= xs, then nx=0 and dir_x flips to +, hit_x=1. Otherwise nx=x-xs.
  - y is identical using BOX_H/DRAW_H.
- Speed 0 on an axis: no motion, no hit, direction held.
- Pause=1: CALC states keep nx=x, ny=y. No pos_upd, no hits.
- Config handshake:
  - cfg_ready=1 only in IDLE.
  - On accept, the fields latch into a shadow register and a pending flag is set.
  - Shadow values are applied to xs/ys/pause on the next tick, before CALC_X, so they affect that frame's step.
  - A second accept before the tick overwrites the shadow (last wins).
  - cfg_valid while not ready is held by the requester; it is not dropped.
- Tick arriving in a non-IDLE state is ignored. This cannot occur when the vsync period exceeds 4 cycles.
- Corner case: both axes hitting in the same frame pulses hit_x and hit_y together.
- rst mid-FSM: immediate return to reset values, and the pending shadow is discarded.

Optional Feature:
SPRITE_MOTION_WRAP_EN:
- Defined: edges wrap instead of reflecting.
  - Moving + with x+xs > DRAW_W-BOX_W gives nx = x+xs-(DRAW_W-BOX_W)-1.
  - Moving - with x < xs gives nx = (DRAW_W-BOX_W)+1-(xs-x).
  - dir never flips. hit_x/hit_y pulse on every wrap.
- Undefined: reflect behaviour as above.

Decomposition:
- Shared package sprite_pkg holds the state enum (IDLE, CALC_X, CALC_Y, PUBLISH), the dir encoding (0=+, 1=-), and the default-geometry constants.
- One natural sub-module, axis_step: combinational per-axis next position, direction and hit, given pos, spd, dir and limit.
  - Instantiated twice, once for x and once for y.
  - The wrap macro is honoured inside axis_step.

Test Plan:
1. Reset, then 3 vsync pulses with defaults → box_x=box_y=3 after the third tick + 4 cycles. pos_upd pulses 3 times.
2. Preload x=588 heading + with xs=4 → next frame box_x=590, hit_x=1. Following frame box_x=586.
3. Preload y=2 heading - with ys=5 → next frame box_y=0, hit_y=1. Following frame box_y=5.
4. cfg_valid in IDLE with xs=7, ys=0, pause=0 → cfg_ready=1 handshake. On the next frame x advances by 7, y is unchanged, and there is no hit_y.
5. cfg_pause=1 accepted → 5 frames with box_x/box_y constant and no pos_upd. Then pause=0 resumes from the same origin.
6. Assert rst during CALC_Y → outputs are 0 the same cycle and the pending shadow is discarded. With SPRITE_MOTION_WRAP_EN, x=589, xs=3 → box_x=1.
